// File: rtl/decode_stage_param_if.sv
// Decode-stage bus: fetch inputs, D register contents, decoded indices and
// operands, downstream forwarding sources, hazard flag and debug read port.
interface decode_stage_param_if #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 4
);
  // Fetch side
  logic [3:0]        f_icode;
  logic [3:0]        f_ifun;
  logic [REG_AW-1:0] f_rA;
  logic [REG_AW-1:0] f_rB;
  logic [DATA_W-1:0] f_valC;
  logic [DATA_W-1:0] f_valP;
  logic [2:0]        f_stat;

  // D register control
  logic              D_stall;
  logic              D_bubble;

  // Forwarding sources from execute, memory and write-back
  logic [REG_AW-1:0] e_dstE;
  logic [REG_AW-1:0] M_dstE;
  logic [REG_AW-1:0] M_dstM;
  logic [REG_AW-1:0] W_dstE;
  logic [REG_AW-1:0] W_dstM;
  logic [DATA_W-1:0] e_valE;
  logic [DATA_W-1:0] M_valE;
  logic [DATA_W-1:0] m_valM;
  logic [DATA_W-1:0] W_valE;
  logic [DATA_W-1:0] W_valM;

  // E register fields used by the load-use detector
  logic [3:0]        E_icode;
  logic [REG_AW-1:0] E_dstM;

  // D register contents
  logic [3:0]        D_icode;
  logic [3:0]        D_ifun;
  logic [REG_AW-1:0] D_rA;
  logic [REG_AW-1:0] D_rB;
  logic [DATA_W-1:0] D_valC;
  logic [DATA_W-1:0] D_valP;
  logic [2:0]        D_stat;

  // Decoded outputs
  logic [REG_AW-1:0] d_srcA;
  logic [REG_AW-1:0] d_srcB;
  logic [REG_AW-1:0] d_dstE;
  logic [REG_AW-1:0] d_dstM;
  logic [DATA_W-1:0] d_valA;
  logic [DATA_W-1:0] d_valB;
  logic              load_use;

  // Debug read port
  logic [REG_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat,
    output D_stall, D_bubble,
    output e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
    output e_valE, M_valE, m_valM, W_valE, W_valM,
    output E_icode, E_dstM, dbg_addr,
    input  D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat,
    input  d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB, load_use,
    input  dbg_data
  );

  modport slave (
    input  f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat,
    input  D_stall, D_bubble,
    input  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
    input  e_valE, M_valE, m_valM, W_valE, W_valM,
    input  E_icode, E_dstM, dbg_addr,
    output D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat,
    output d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB, load_use,
    output dbg_data
  );
endinterface

// File: rtl/decode_stage_param.sv
// Parametrised Y86-64 decode stage: D pipeline register, two-write-port
// resettable register file, source/destination selection, five-source
// forwarding with RNONE qualification, and a load-use hazard detector.
module decode_stage_param #(
  parameter int                DATA_W   = 64,
  parameter int                REG_AW   = 4,
  parameter int                NUM_REGS = 15,
  parameter logic [REG_AW-1:0] RNONE    = {REG_AW{1'b1}}
) (
  input logic                 clk,
  input logic                 rst,
  decode_stage_param_if.slave bus
);

  localparam logic [3:0]        I_NOP    = 4'h1;
  localparam logic [2:0]        STAT_AOK = 3'd1;
  localparam logic [REG_AW-1:0] RSP      = REG_AW'(4);

  // D pipeline register
  logic [3:0]        dIcode;
  logic [3:0]        dIfun;
  logic [REG_AW-1:0] dRA;
  logic [REG_AW-1:0] dRB;
  logic [DATA_W-1:0] dValC;
  logic [DATA_W-1:0] dValP;
  logic [2:0]        dStat;

  // Register file and decode results
  logic [DATA_W-1:0] regFile [NUM_REGS];
  logic [REG_AW-1:0] srcA;
  logic [REG_AW-1:0] srcB;
  logic [REG_AW-1:0] dstE;
  logic [REG_AW-1:0] dstM;
  logic [DATA_W-1:0] rfValA;
  logic [DATA_W-1:0] rfValB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;

  // True when an index names an implemented register (RNONE never does).
  function automatic logic inRange(input logic [REG_AW-1:0] idx);
    return (idx != RNONE) && (int'(idx) < NUM_REGS);
  endfunction

  // First matching downstream producer wins; a src of RNONE never matches,
  // so a consumer without a source cannot pick up a producer without a dest.
  function automatic logic [DATA_W-1:0] fwdPick(
    input logic [REG_AW-1:0] src,
    input logic [DATA_W-1:0] rfVal,
    input logic [REG_AW-1:0] eDstE, input logic [DATA_W-1:0] eValE,
    input logic [REG_AW-1:0] mDstM, input logic [DATA_W-1:0] mValM,
    input logic [REG_AW-1:0] mDstE, input logic [DATA_W-1:0] mValE,
    input logic [REG_AW-1:0] wDstM, input logic [DATA_W-1:0] wValM,
    input logic [REG_AW-1:0] wDstE, input logic [DATA_W-1:0] wValE
  );
    if (src == RNONE)      return rfVal;
    else if (eDstE == src) return eValE;
    else if (mDstM == src) return mValM;
    else if (mDstE == src) return mValE;
    else if (wDstM == src) return wValM;
    else if (wDstE == src) return wValE;
    else                   return rfVal;
  endfunction

  // D register: stall holds everything, bubble injects a NOP but keeps valC/valP.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dIcode <= I_NOP;
      dIfun  <= '0;
      dRA    <= RNONE;
      dRB    <= RNONE;
      dValC  <= '0;
      dValP  <= '0;
      dStat  <= STAT_AOK;
    end else if (bus.D_stall) begin
      dIcode <= dIcode;
    end else if (bus.D_bubble) begin
      dIcode <= I_NOP;
      dIfun  <= '0;
      dRA    <= RNONE;
      dRB    <= RNONE;
      dStat  <= STAT_AOK;
    end else begin
      dIcode <= bus.f_icode;
      dIfun  <= bus.f_ifun;
      dRA    <= bus.f_rA;
      dRB    <= bus.f_rB;
      dValC  <= bus.f_valC;
      dValP  <= bus.f_valP;
      dStat  <= bus.f_stat;
    end
  end

  // Register file writes: valE port first, valM port second so valM wins a tie.
  // NOTE: this array is deliberately reset, which forces flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
    end else begin
      if (inRange(bus.W_dstE)) regFile[bus.W_dstE] <= bus.W_valE;
      if (inRange(bus.W_dstM)) regFile[bus.W_dstM] <= bus.W_valM;
    end
  end

  // Source and destination register selection from the D icode.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    unique case (dIcode)
      4'h2, 4'h4, 4'h6, 4'hA: srcA = dRA;
      4'h9, 4'hB:             srcA = RSP;
      default:                srcA = RNONE;
    endcase
    unique case (dIcode)
      4'h4, 4'h5, 4'h6:       srcB = dRB;
      4'h8, 4'h9, 4'hA, 4'hB: srcB = RSP;
      default:                srcB = RNONE;
    endcase
    unique case (dIcode)
      4'h2, 4'h3, 4'h6:       dstE = dRB;
      4'h8, 4'h9, 4'hA, 4'hB: dstE = RSP;
      default:                dstE = RNONE;
    endcase
    unique case (dIcode)
      4'h5, 4'hB:             dstM = dRA;
      default:                dstM = RNONE;
    endcase
  end

  // Combinational register reads; RNONE and unimplemented indices read zero.
  always_comb begin
    rfValA = '0;
    rfValB = '0;
    if (inRange(srcA)) rfValA = regFile[srcA];
    if (inRange(srcB)) rfValB = regFile[srcB];
  end

  // Operand selection: call/jump take valP, everything else goes through forwarding.
  always_comb begin
    valA = '0;
    valB = '0;
    if (dIcode == 4'h7 || dIcode == 4'h8) begin
      valA = dValP;
    end else begin
      valA = fwdPick(srcA, rfValA, bus.e_dstE, bus.e_valE, bus.M_dstM, bus.m_valM,
                     bus.M_dstE, bus.M_valE, bus.W_dstM, bus.W_valM,
                     bus.W_dstE, bus.W_valE);
    end
    valB = fwdPick(srcB, rfValB, bus.e_dstE, bus.e_valE, bus.M_dstM, bus.m_valM,
                   bus.M_dstE, bus.M_valE, bus.W_dstM, bus.W_valM,
                   bus.W_dstE, bus.W_valE);
  end

  // Output drive: D contents, decode results, load-use flag and debug read.
  always_comb begin
    bus.D_icode  = dIcode;
    bus.D_ifun   = dIfun;
    bus.D_rA     = dRA;
    bus.D_rB     = dRB;
    bus.D_valC   = dValC;
    bus.D_valP   = dValP;
    bus.D_stat   = dStat;
    bus.d_srcA   = srcA;
    bus.d_srcB   = srcB;
    bus.d_dstE   = dstE;
    bus.d_dstM   = dstM;
    bus.d_valA   = valA;
    bus.d_valB   = valB;
    bus.load_use = (bus.E_icode == 4'h5 || bus.E_icode == 4'hB) &&
                   (bus.E_dstM != RNONE) &&
                   (bus.E_dstM == srcA || bus.E_dstM == srcB);
    bus.dbg_data = inRange(bus.dbg_addr) ? regFile[bus.dbg_addr] : '0;
  end

endmodule
